// File: rtl/adc_fft_pkg.sv
// rtl/adc_fft_pkg.sv - shared FSM encoding, defaults and sample conversion for the ADC-to-FFT path
package adc_fft_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_LVL = 2'd1,
    BURST    = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  localparam int FFT_LOG2_DEF = 10;

  // Offset-binary to two's complement is just an MSB flip at the given width.
  function automatic logic [31:0] offset_to_signed(input logic [31:0] d, input int width, input bit en);
    return en ? (d ^ (32'd1 << (width - 1))) : d;
  endfunction

endpackage

// File: rtl/adc_frame_reader_if.sv
// rtl/adc_frame_reader_if.sv - FIFO read port and FFT sample stream seen by the frame reader
interface adc_frame_reader_if
  import adc_fft_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int LVL_WIDTH  = 12,
  parameter int FFT_LOG2   = FFT_LOG2_DEF
) ();

  logic [DATA_WIDTH-1:0] fifo_rd_data;
  logic                  fifo_rd_empty;
  logic [LVL_WIDTH-1:0]  fifo_rd_water_level;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;
  logic [FFT_LOG2-1:0]   m_index;

  modport master (
    input  fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last, m_index
  );

  modport slave (
    output fifo_rd_data, fifo_rd_empty, fifo_rd_water_level, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last, m_index
  );

endinterface

// File: rtl/adc_skid_buf.sv
// rtl/adc_skid_buf.sv - 2-entry valid/ready buffer; the producer must only push when room is guaranteed
module adc_skid_buf #(
  parameter int WIDTH = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_tdata_i,
  input  logic             s_tvalid_i,
  output logic [WIDTH-1:0] m_tdata_o,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic [1:0]       occ_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             push, pop;

  assign pop        = m_tvalid_o & m_tready_i;
  // A full buffer may still accept when the head leaves in the same cycle.
  assign push       = s_tvalid_i & ((cnt_q != 2'd2) | pop);
  assign m_tvalid_o = (cnt_q != 2'd0);
  assign m_tdata_o  = mem_q[rd_ptr_q];
  assign occ_o      = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 2'd1;
    else if (pop && !push) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_tdata_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_frame_reader.sv
// rtl/adc_frame_reader.sv - waits for a full frame in the ADC FIFO, then bursts it to the FFT as a stream
module adc_frame_reader
  import adc_fft_pkg::*;
#(
  parameter int DATA_WIDTH = 12,
  parameter int LVL_WIDTH  = 12,
  parameter int FFT_LOG2   = FFT_LOG2_DEF,
  parameter int OFFSET_BIN = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  adc_frame_reader_if.master        bus,
  input  logic                      start,
  input  logic                      cont_mode,
  output logic                      busy,
  output logic                      underrun,
  output logic [15:0]               frame_cnt
);

  localparam int FFT_LEN = 1 << FFT_LOG2;
  localparam int PW      = DATA_WIDTH + FFT_LOG2 + 1;
  localparam logic [FFT_LOG2:0]   LEN_W   = (FFT_LOG2 + 1)'(FFT_LEN);
  localparam logic [FFT_LOG2:0]   LEN_M1  = (FFT_LOG2 + 1)'(FFT_LEN - 1);
  localparam logic [FFT_LOG2-1:0] IDX_MAX = '1;

  state_e                state_q, state_d;
  logic [FFT_LOG2:0]     issued_q, issued_d;
  logic [FFT_LOG2-1:0]   wr_idx_q, wr_idx_d;
  logic                  inflight_q;
  logic                  underrun_q, underrun_d;
  logic [15:0]           frame_q, frame_d;
  logic [1:0]            occ;
  logic [PW-1:0]         push_data, pop_data;
  logic [DATA_WIDTH-1:0] conv;
  logic                  pop, rd_en, level_ok;

  assign conv      = DATA_WIDTH'(offset_to_signed(32'(bus.fifo_rd_data), DATA_WIDTH, OFFSET_BIN != 0));
  assign push_data = {conv, wr_idx_q, wr_idx_q == IDX_MAX};
  assign level_ok  = 32'(bus.fifo_rd_water_level) >= 32'(FFT_LEN);
  assign pop       = bus.m_valid & bus.m_ready;

  // Room check counts the beat leaving this cycle so a steady stream runs at one sample per clock.
  assign rd_en = (state_q == BURST) & ~bus.fifo_rd_empty & (issued_q != LEN_W)
               & (({1'b0, occ} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));

  adc_skid_buf #(.WIDTH(PW)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tdata_i  (push_data),
    .s_tvalid_i (inflight_q),
    .m_tdata_o  (pop_data),
    .m_tvalid_o (bus.m_valid),
    .m_tready_i (bus.m_ready),
    .occ_o      (occ)
  );

  assign {bus.m_data, bus.m_index, bus.m_last} = pop_data;
  assign bus.fifo_rd_en = rd_en;
  assign busy           = (state_q != IDLE);
  assign underrun       = underrun_q;
  assign frame_cnt      = frame_q;

  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    wr_idx_d   = wr_idx_q;
    underrun_d = underrun_q;
    frame_d    = frame_q;
    if (rd_en) issued_d = issued_q + (FFT_LOG2 + 1)'(1);
    if (inflight_q) wr_idx_d = wr_idx_q + FFT_LOG2'(1);
    if (pop && bus.m_last) frame_d = frame_q + 16'd1;
    case (state_q)
      IDLE: begin
        if (start || cont_mode) state_d = WAIT_LVL;
        if (start) underrun_d = 1'b0;
      end
      WAIT_LVL: begin
        if (level_ok) begin
          state_d  = BURST;
          issued_d = '0;
          wr_idx_d = '0;
        end
      end
      BURST: begin
        if (bus.fifo_rd_empty && issued_q != LEN_W) underrun_d = 1'b1;
        if (rd_en && issued_q == LEN_M1) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && bus.m_last) state_d = cont_mode ? WAIT_LVL : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      wr_idx_q   <= '0;
      inflight_q <= 1'b0;
      underrun_q <= 1'b0;
      frame_q    <= '0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      wr_idx_q   <= wr_idx_d;
      inflight_q <= rd_en;
      underrun_q <= underrun_d;
      frame_q    <= frame_d;
    end
  end

endmodule

// File: tb/tb_adc_frame_reader.sv
// tb/tb_adc_frame_reader.sv - randomized bench with a FIFO model and a sample-order reference for adc_frame_reader
module tb_adc_frame_reader;
  import adc_fft_pkg::*;

  localparam int LEN = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, cont_mode, busy, underrun;
  logic [15:0] frame_cnt;

  adc_frame_reader_if bus ();

  adc_frame_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .start     (start),
    .cont_mode (cont_mode),
    .busy      (busy),
    .underrun  (underrun),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [11:0] fq[$];
  logic [11:0] hist[$];
  int          n_reads   = 0;
  int          ready_pct = 100;
  bit          force_e   = 1'b0;
  logic [11:0] desc_val  = 12'hFFF;

  function automatic logic [11:0] conv_model(input logic [11:0] v);
    return {~v[11], v[10:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic upd_lvl();
    bus.fifo_rd_water_level = 12'(fq.size());
    bus.fifo_rd_empty       = force_e || (fq.size() == 0);
  endtask

  task automatic put(input int n, input bit desc);
    logic [11:0] v;
    for (int i = 0; i < n; i++) begin
      if (desc) begin
        v = desc_val;
        desc_val = desc_val - 12'd1;
      end else begin
        v = 12'($urandom);
      end
      fq.push_back(v);
      hist.push_back(v);
    end
    upd_lvl();
  endtask

  // One clock: FIFO model returns data the cycle after a sampled read strobe.
  task automatic tick();
    logic rd_s;
    @(negedge clk);
    rd_s = bus.fifo_rd_en;
    @(posedge clk);
    #1;
    if (rd_s && fq.size() > 0) begin
      bus.fifo_rd_data = fq.pop_front();
      n_reads++;
    end
    bus.m_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
    upd_lvl();
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frame_cnt != 16'(target) && n < budget) begin
      tick();
      n++;
    end
    chk(name, 32'(frame_cnt), target);
  endtask

  int          exp_ptr = 0, beats = 0, frames = 0, acc = 0, rd_base = 0;
  bit          prev_stall = 1'b0;
  logic [11:0] p_data;
  logic [9:0]  p_idx;
  logic        p_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_ptr    = hist.size();
      beats      = 0;
      frames     = 0;
      acc        = 0;
      rd_base    = n_reads;
      prev_stall = 1'b0;
    end else begin
      chk("frame_cnt", 32'(frame_cnt), frames);
      if (bus.fifo_rd_en) begin
        chk("rd_en_while_empty", 32'(bus.fifo_rd_empty), 0);
        chk("rd_en_buffer_room",
            32'((n_reads - rd_base - acc - int'(bus.m_valid && bus.m_ready)) < 2), 1);
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.m_valid), 1);
        chk("stall_data", 32'(bus.m_data), 32'(p_data));
        chk("stall_index", 32'(bus.m_index), 32'(p_idx));
        chk("stall_last", 32'(bus.m_last), 32'(p_last));
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("beat_expected", 32'(exp_ptr < hist.size()), 1);
        if (exp_ptr < hist.size()) begin
          chk("m_data", 32'(bus.m_data), 32'(conv_model(hist[exp_ptr])));
          chk("m_index", 32'(bus.m_index), beats % LEN);
          chk("m_last", 32'(bus.m_last), 32'((beats % LEN) == LEN - 1));
        end
        exp_ptr++;
        beats++;
        acc++;
        if (beats % LEN == 0) frames++;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      p_data     = bus.m_data;
      p_idx      = bus.m_index;
      p_last     = bus.m_last;
    end
  end

  initial begin
    int rd0, n, gaps;
    rst_n = 1'b0; start = 1'b0; cont_mode = 1'b0;
    bus.m_ready = 1'b1; bus.fifo_rd_data = '0;
    upd_lvl();
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_m_valid", 32'(bus.m_valid), 0);
    chk("rst_m_data", 32'(bus.m_data), 0);
    chk("rst_m_index", 32'(bus.m_index), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    tick();

    // Level gate: one sample short of a frame must not start the burst.
    put(LEN - 1, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    rd0 = n_reads;
    repeat (40) tick();
    chk("gate_no_read", n_reads, rd0);
    chk("gate_busy", 32'(busy), 1);
    put(1, 1'b0);
    wait_frames(1, 3000, "gate_frame");
    chk("gate_idle", 32'(busy), 0);

    // Descending pattern at full rate, with pinned first/last values.
    put(LEN, 1'b1);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    while (!bus.m_valid && n < 50) begin tick(); n++; end
    chk("first_valid_latency", n, 3);
    gaps = 0;
    for (int k = 0; k < LEN; k++) begin
      if (k == 0) begin
        chk("first_data", 32'(bus.m_data), 32'h7FF);
        chk("first_index", 32'(bus.m_index), 0);
      end
      if (k == LEN - 1) begin
        chk("last_data", 32'(bus.m_data), 32'h400);
        chk("last_index", 32'(bus.m_index), 32'h3FF);
        chk("last_flag", 32'(bus.m_last), 1);
      end
      if (!bus.m_valid) gaps++;
      tick();
    end
    chk("burst_gaps", gaps, 0);
    chk("data_frame", 32'(frame_cnt), 2);

    // Random backpressure.
    ready_pct = 50;
    put(LEN, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    wait_frames(3, 8000, "bp_frame");
    ready_pct = 100;
    tick();

    // Continuous mode: three frames back to back, then parked in WAIT_LVL.
    cont_mode = 1'b1;
    put(3 * LEN, 1'b0);
    wait_frames(6, 8000, "cont_frames");
    chk("cont_busy", 32'(busy), 1);
    cont_mode = 1'b0;
    rd0 = n_reads;
    repeat (20) tick();
    chk("cont_wait_no_read", n_reads, rd0);

    // Underrun: forced empty mid-burst.
    chk("pre_underrun", 32'(underrun), 0);
    rd0 = n_reads;
    put(LEN, 1'b0);
    n = 0;
    while (n_reads < rd0 + 300 && n < 2000) begin tick(); n++; end
    chk("ur_reach", 32'(n_reads >= rd0 + 300), 1);
    force_e = 1'b1; upd_lvl();
    rd0 = n_reads;
    repeat (5) tick();
    chk("ur_stalled", n_reads, rd0);
    chk("ur_flag", 32'(underrun), 1);
    force_e = 1'b0; upd_lvl();
    wait_frames(7, 3000, "ur_frame");
    chk("ur_sticky", 32'(underrun), 1);
    tick();
    chk("ur_idle", 32'(busy), 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("ur_cleared", 32'(underrun), 0);
    chk("ur_rearmed", 32'(busy), 1);

    // Asynchronous reset in the middle of a burst.
    rd0 = n_reads;
    put(LEN, 1'b0);
    n = 0;
    while (n_reads < rd0 + 200 && n < 2000) begin tick(); n++; end
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(bus.m_valid), 0);
    chk("mid_rst_m_data", 32'(bus.m_data), 0);
    chk("mid_rst_m_index", 32'(bus.m_index), 0);
    chk("mid_rst_m_last", 32'(bus.m_last), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rd_en", 32'(bus.fifo_rd_en), 0);
    chk("mid_rst_frame_cnt", 32'(frame_cnt), 0);
    fq.delete();
    upd_lvl();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    put(LEN, 1'b0);
    start = 1'b1; tick(); start = 1'b0;
    wait_frames(1, 3000, "post_rst_frame");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
